// File: rtl/conv_feed_scheduler.sv
// Sequencer feeding the 3x3 convolution datapath: captures a 4x4 byte tile and a 3x3 filter,
// clears the systolic arrays, streams skewed operands for 13 steps, drains, then pulses done.
module conv_feed_scheduler #(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] data,
    input  logic [71:0]  filter,
    output logic         busy,
    output logic         done,
    output logic         arr_rst,
    output logic [63:0]  feed_a,
    output logic [23:0]  feed_b,
    output logic [7:0]   a1,
    output logic [7:0]   a2,
    output logic [7:0]   b1,
    output logic [7:0]   b2,
    output logic [3:0]   step
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_STEP  = 4'd12;
    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [3:0]   r_step;
    logic [3:0]   w_step_nxt;
    logic [3:0]   r_drain;
    logic [3:0]   w_drain_nxt;
    logic         w_capture;
    logic [127:0] r_data;
    logic [71:0]  r_filter;

    logic [63:0]  w_feed_a;
    logic [23:0]  w_feed_b;
    logic [7:0]   w_a1;
    logic [7:0]   w_a2;
    logic [7:0]   w_b1;
    logic [7:0]   w_b2;

    function automatic logic [7:0] tile_byte(input logic [127:0] d, input logic [3:0] k);
        return d[{k, 3'b000} +: 8];
    endfunction

    // Filter rows go out highest column first, so lane 0 carries F[r][2].
    function automatic logic [23:0] row_reversed(input logic [23:0] row);
        return {row[7:0], row[15:8], row[23:16]};
    endfunction

    // 2x2 weight schedule: F[2-k/4][2-k%4], with a bubble every fourth step and after step 11.
    function automatic logic [7:0] pick_b1(input logic [71:0] f, input logic [3:0] k);
        logic [3:0] idx;
        if (k >= 4'd12 || k[1:0] == 2'd3) begin
            return 8'd0;
        end
        idx = 4'd8 - (4'd3 * {2'b00, k[3:2]}) - {2'b00, k[1:0]};
        return f[{idx, 3'b000} +: 8];
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = 4'd0;
        w_drain_nxt = 4'd0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_CLR;
                    w_capture   = 1'b1;
                end
            end
            S_CLR: begin
                w_state_nxt = S_FEED;
            end
            S_FEED: begin
                if (r_step == LAST_STEP) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_step_nxt = r_step + 4'd1;
                end
            end
            S_DRAIN: begin
                if (r_drain == DRAIN_LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_drain_nxt = r_drain + 4'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operands are computed for the upcoming step so every output leaves a flop.
    always_comb begin
        w_feed_a = 64'd0;
        w_feed_b = 24'd0;
        w_a1     = 8'd0;
        w_a2     = 8'd0;
        w_b1     = 8'd0;
        w_b2     = 8'd0;
        if (w_state_nxt == S_FEED) begin
            case (w_step_nxt)
                4'd0: begin
                    w_feed_a = r_data[63:0];
                    w_feed_b = row_reversed(r_filter[71:48]);
                end
                4'd1: begin
                    w_feed_a = r_data[95:32];
                    w_feed_b = row_reversed(r_filter[47:24]);
                end
                4'd2: begin
                    w_feed_a = r_data[127:64];
                    w_feed_b = row_reversed(r_filter[23:0]);
                end
                default: begin
                    w_feed_a = 64'd0;
                    w_feed_b = 24'd0;
                end
            endcase
            w_a1 = (w_step_nxt < LAST_STEP) ? tile_byte(r_data, w_step_nxt) : 8'd0;
            w_a2 = (w_step_nxt == 4'd0) ? 8'd0 : tile_byte(r_data, w_step_nxt + 4'd3);
            w_b1 = pick_b1(r_filter, w_step_nxt);
            w_b2 = (w_step_nxt >= 4'd2) ? pick_b1(r_filter, w_step_nxt - 4'd2) : 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_step  <= 4'd0;
            r_drain <= 4'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            arr_rst <= 1'b1;
            feed_a  <= 64'd0;
            feed_b  <= 24'd0;
            a1      <= 8'd0;
            a2      <= 8'd0;
            b1      <= 8'd0;
            b2      <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_drain <= w_drain_nxt;
            busy    <= (w_state_nxt != S_IDLE);
            done    <= (w_state_nxt == S_DONE);
            arr_rst <= (w_state_nxt == S_CLR);
            feed_a  <= w_feed_a;
            feed_b  <= w_feed_b;
            a1      <= w_a1;
            a2      <= w_a2;
            b1      <= w_b1;
            b2      <= w_b2;
        end
    end

    // Operand snapshot; only the accepted start loads it, so later input changes are invisible.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_data   <= data;
            r_filter <= filter;
        end
    end

    assign step = r_step;

endmodule

// File: tb/tb_conv_feed_scheduler.sv
// Directed bench for conv_feed_scheduler: per-step operand stream, latency, back-to-back
// acceptance, mid-job reset and a DRAIN_CYCLES=5 instance.
module tb_conv_feed_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         start5;
    logic [127:0] data;
    logic [71:0]  filter;

    logic         busy, done, arr_rst;
    logic [63:0]  feed_a;
    logic [23:0]  feed_b;
    logic [7:0]   a1, a2, b1, b2;
    logic [3:0]   step;

    logic         busy5, done5, arr_rst5;
    logic [63:0]  feed_a5;
    logic [23:0]  feed_b5;
    logic [7:0]   a1_5, a2_5, b1_5, b2_5;
    logic [3:0]   step5;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] cap_fa0;
    logic [23:0] cap_fb0;
    logic [31:0] cap_s4;
    int          acc3;
    int          acc2;

    always #5 clk = ~clk;

    conv_feed_scheduler #(.DRAIN_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .data(data), .filter(filter),
        .busy(busy), .done(done), .arr_rst(arr_rst), .feed_a(feed_a), .feed_b(feed_b),
        .a1(a1), .a2(a2), .b1(b1), .b2(b2), .step(step)
    );

    conv_feed_scheduler #(.DRAIN_CYCLES(5)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .data(data), .filter(filter),
        .busy(busy5), .done(done5), .arr_rst(arr_rst5), .feed_a(feed_a5), .feed_b(feed_b5),
        .a1(a1_5), .a2(a2_5), .b1(b1_5), .b2(b2_5), .step(step5)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] dt(input logic [127:0] d, input int i);
        return d[8*i +: 8];
    endfunction

    function automatic logic [7:0] ft(input logic [71:0] f, input int r, input int c);
        return f[8*(3*r+c) +: 8];
    endfunction

    function automatic logic [63:0] exp_fa(input logic [127:0] d, input int k);
        logic [63:0] v;
        v = 64'd0;
        if (k < 3) begin
            for (int j = 0; j < 8; j++) v[8*j +: 8] = dt(d, 4*k + j);
        end
        return v;
    endfunction

    function automatic logic [23:0] exp_fb(input logic [71:0] f, input int k);
        logic [23:0] v;
        v = 24'd0;
        if (k < 3) begin
            for (int j = 0; j < 3; j++) v[8*j +: 8] = ft(f, 2 - k, 2 - j);
        end
        return v;
    endfunction

    function automatic logic [7:0] exp_b1(input logic [71:0] f, input int k);
        if (k >= 12 || (k % 4) == 3) return 8'd0;
        return ft(f, 2 - k / 4, 2 - (k % 4));
    endfunction

    function automatic logic [31:0] exp_2x2(input logic [127:0] d, input logic [71:0] f, input int k);
        logic [7:0] e1, e2, e3, e4;
        e1 = (k < 12) ? dt(d, k) : 8'd0;
        e2 = (k == 0) ? 8'd0 : dt(d, k + 3);
        e3 = exp_b1(f, k);
        e4 = (k >= 2) ? exp_b1(f, k - 2) : 8'd0;
        return {e1, e2, e3, e4};
    endfunction

    task automatic run_job(input logic [127:0] d, input logic [71:0] f, input bit mod_data,
                           input string tag);
        int lat;
        data   = d;
        filter = f;
        start  = 1'b1;
        acc3   = 0;
        acc2   = 0;
        tick;
        start = 1'b0;
        check({tag, ".clr_busy"}, 128'(busy), 128'(1'b1));
        check({tag, ".clr_arr_rst"}, 128'(arr_rst), 128'(1'b1));
        check({tag, ".clr_feeds"}, {feed_a, feed_b, a1, a2, b1, b2}, 128'd0);
        for (int k = 0; k < 13; k++) begin
            tick;
            if (mod_data && k == 2) begin
                data   = ~d;
                filter = ~f;
            end
            check($sformatf("%s.step%0d", tag, k), 128'(step), 128'(k));
            check($sformatf("%s.arr_rst%0d", tag, k), 128'(arr_rst), 128'(1'b0));
            check($sformatf("%s.feed_a%0d", tag, k), 128'(feed_a), 128'(exp_fa(d, k)));
            check($sformatf("%s.feed_b%0d", tag, k), 128'(feed_b), 128'(exp_fb(f, k)));
            check($sformatf("%s.2x2_%0d", tag, k), 128'({a1, a2, b1, b2}), 128'(exp_2x2(d, f, k)));
            if (k == 0) begin
                cap_fa0 = feed_a;
                cap_fb0 = feed_b;
            end
            if (k == 4) cap_s4 = {a1, a2, b1, b2};
            for (int j = 0; j < 3; j++) acc3 += int'(feed_a[8*j +: 8]) * int'(feed_b[8*j +: 8]);
            acc2 += int'(a1) * int'(b1);
        end
        tick;
        check({tag, ".drain_feeds"}, {feed_a, feed_b, a1, a2, b1, b2}, 128'd0);
        check({tag, ".drain_done"}, 128'(done), 128'(1'b0));
        lat = 14;
        while (done !== 1'b1 && lat < 40) begin
            tick;
            lat++;
        end
        check({tag, ".latency"}, 128'(lat), 128'(16));
        check({tag, ".busy_at_done"}, 128'(busy), 128'(1'b1));
        tick;
        check({tag, ".idle_done"}, 128'(done), 128'(1'b0));
        check({tag, ".idle_busy"}, 128'(busy), 128'(1'b0));
    endtask

    initial begin
        logic [127:0] tile_a;
        logic [71:0]  filt_a;
        logic [127:0] tile_b;
        logic [71:0]  filt_b;
        int           cyc_done[$];
        int           run_len;
        int           max_run;
        int           cnt;
        int           lat5;

        tile_a = 128'h1F1E1D1C1B1A19181716151413121110;
        filt_a = 72'h090807060504030201;
        tile_b = 128'h0123456789ABCDEFFEDCBA9876543210;
        filt_b = 72'h112233445566778899;

        rst    = 1'b1;
        start  = 1'b0;
        start5 = 1'b0;
        data   = 128'd0;
        filter = 72'd0;
        repeat (3) tick;
        check("rst.busy", 128'(busy), 128'(1'b0));
        check("rst.done", 128'(done), 128'(1'b0));
        check("rst.arr_rst", 128'(arr_rst), 128'(1'b1));
        check("rst.outs", {feed_a, feed_b, a1, a2, b1, b2}, 128'd0);
        check("rst.step", 128'(step), 128'd0);
        rst = 1'b0;
        tick;
        check("rel.arr_rst", 128'(arr_rst), 128'(1'b0));
        check("rel.busy", 128'(busy), 128'(1'b0));

        run_job(tile_a, filt_a, 1'b0, "ramp");
        check("ramp.hand_fa0", 128'(cap_fa0), 128'(64'h1716151413121110));
        check("ramp.hand_fb0", 128'(cap_fb0), 128'(24'h070809));
        check("ramp.hand_s4", 128'(cap_s4), 128'(32'h14170607));

        run_job({16{8'h01}}, {9{8'h01}}, 1'b0, "ones");
        check("ones.conv3", 128'(acc3), 128'd9);
        check("ones.conv2", 128'(acc2), 128'd9);

        run_job(tile_a, filt_a, 1'b1, "moddata");

        // start held high: record the cycle of every done pulse
        data   = tile_b;
        filter = filt_b;
        start  = 1'b1;
        run_len = 0;
        max_run = 0;
        for (int c = 1; c <= 60; c++) begin
            tick;
            if (done === 1'b1) begin
                cyc_done.push_back(c);
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
        end
        start = 1'b0;
        check("b2b.count", 128'(cyc_done.size()), 128'd3);
        if (cyc_done.size() == 3) begin
            check("b2b.first", 128'(cyc_done[0]), 128'd17);
            check("b2b.gap1", 128'(cyc_done[1] - cyc_done[0]), 128'd18);
            check("b2b.gap2", 128'(cyc_done[2] - cyc_done[1]), 128'd18);
        end
        check("b2b.width", 128'(max_run), 128'd1);
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            tick;
            cnt++;
        end
        check("b2b.drained", 128'(busy), 128'(1'b0));

        // abort at step 6; rst and start together must leave it idle
        data   = tile_a;
        filter = filt_a;
        start  = 1'b1;
        tick;
        start = 1'b0;
        repeat (7) tick;
        check("abort.step6", 128'(step), 128'd6);
        rst   = 1'b1;
        start = 1'b1;
        tick;
        check("abort.busy", 128'(busy), 128'(1'b0));
        check("abort.arr_rst", 128'(arr_rst), 128'(1'b1));
        check("abort.outs", {feed_a, feed_b, a1, a2, b1, b2, 4'(step)}, 128'd0);
        rst   = 1'b0;
        start = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick;
            if (done === 1'b1 || busy === 1'b1) cnt++;
        end
        check("abort.no_done", 128'(cnt), 128'd0);
        run_job(tile_b, filt_b, 1'b0, "after_abort");

        // DRAIN_CYCLES=5 instance latency
        data   = tile_a;
        filter = filt_a;
        start5 = 1'b1;
        tick;
        start5 = 1'b0;
        lat5 = 1;
        tick;
        while (done5 !== 1'b1 && lat5 < 40) begin
            tick;
            lat5++;
        end
        check("drain5.latency", 128'(lat5), 128'd19);
        check("drain5.busy", 128'(busy5), 128'(1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
